// File: rtl/sisc_mem_pkg.sv
// Shared types and defaults for the SISC single-port memory arbiter.
// State encodings, requester port ids and default bus widths.
package sisc_mem_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/mem_arb_rr_pick2.sv
// Two-requester round-robin picker, purely combinational (zero latency).
// A tie goes to the port that did not win last time; no backpressure.
module rr_pick2
  import sisc_mem_pkg::*;
(
  input  logic req_if,
  input  logic req_dm,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req_if | req_dm;
    if (req_if && req_dm) begin
      grant_id = ~last_grant;
    end else if (req_dm) begin
      grant_id = PORT_DM;
    end else begin
      grant_id = PORT_IF;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates fetch and data requests onto one memory port; write done at grant+1, read done at grant+1+RD_LAT.
// Requests are held by the requester until done; at most one access is in flight, later inputs are ignored.
module mem_arb
  import sisc_mem_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
)
(
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = 3;

  state_t        state_q, state_d;
  logic          last_grant_q;
  logic          grant_valid, grant_id, grant;
  logic          id_q, id_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cap;
  logic          mem_en_d, mem_we_d, if_done_d, dm_done_d, busy_d;

  rr_pick2 u_pick (
    .req_if      (if_req),
    .req_dm      (dm_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign grant     = (state_q == IDLE) && grant_valid;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_DM;
      id_q         <= PORT_IF;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      if_done      <= 1'b0;
      dm_done      <= 1'b0;
      busy         <= 1'b0;
      if_rdata     <= '0;
      dm_rdata     <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      mem_en  <= mem_en_d;
      mem_we  <= mem_we_d;
      if_done <= if_done_d;
      dm_done <= dm_done_d;
      busy    <= busy_d;
      if (grant) last_grant_q <= grant_id;
      // Read data is only ever written by a completing read on its own port.
      if (cap && (id_q == PORT_IF)) if_rdata <= mem_rdata;
      if (cap && (id_q == PORT_DM)) dm_rdata <= mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ISSUE;
      ISSUE:   state_d = we_q ? RESP : WAIT;
      WAIT:    if (cnt_q == CW'(1)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    if (grant) begin
      id_d    = grant_id;
      we_d    = (grant_id == PORT_DM) && dm_we;
      addr_d  = (grant_id == PORT_DM) ? dm_addr : if_addr;
      wdata_d = dm_wdata;
    end
    if (state_q == ISSUE) begin
      cnt_d = CW'(RD_LAT);
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - CW'(1);
    end
    cap = (state_q == WAIT) && (cnt_q == CW'(1));
    // Outputs are registered from the upcoming state so they line up with it.
    mem_en_d  = (state_d == ISSUE);
    mem_we_d  = (state_d == ISSUE) && we_d;
    if_done_d = (state_d == RESP) && (id_d == PORT_IF);
    dm_done_d = (state_d == RESP) && (id_d == PORT_DM);
    busy_d    = (state_d != IDLE);
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: three instances with read latencies 1, 3 and 4 share the request inputs.
module tb_mem_arb;

  logic        clk, rst;
  logic        if_req, dm_req, dm_we;
  logic [15:0] if_addr, dm_addr;
  logic [31:0] dm_wdata;

  logic        if_done1, dm_done1, mem_en1, mem_we1, busy1;
  logic [31:0] if_rdata1, dm_rdata1, mem_wdata1, mem_rdata1;
  logic [15:0] mem_addr1;
  logic        if_done3, dm_done3, mem_en3, mem_we3, busy3;
  logic [31:0] if_rdata3, dm_rdata3, mem_wdata3, mem_rdata3;
  logic [15:0] mem_addr3;
  logic        if_done4, dm_done4, mem_en4, mem_we4, busy4;
  logic [31:0] if_rdata4, dm_rdata4, mem_wdata4, mem_rdata4;
  logic [15:0] mem_addr4;

  logic [31:0] p3a, p3b, p4a, p4b, p4c;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arb #(.AW(16), .DW(32), .RD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_done(if_done1),
    .if_rdata(if_rdata1), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_done(dm_done1), .dm_rdata(dm_rdata1), .mem_en(mem_en1),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1));

  mem_arb #(.AW(16), .DW(32), .RD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_done(if_done3),
    .if_rdata(if_rdata3), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_done(dm_done3), .dm_rdata(dm_rdata3), .mem_en(mem_en3),
    .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3));

  mem_arb #(.AW(16), .DW(32), .RD_LAT(4)) u4 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_done(if_done4),
    .if_rdata(if_rdata4), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_done(dm_done4), .dm_rdata(dm_rdata4), .mem_en(mem_en4),
    .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_rdata(mem_rdata4), .busy(busy4));

  function automatic logic [31:0] mem_val(input logic [15:0] a);
    case (a)
      16'h0010: mem_val = 32'h11223344;
      16'h0020: mem_val = 32'hCAFEF00D;
      16'h0003: mem_val = 32'h0BADC0DE;
      default:  mem_val = {a, ~a};
    endcase
  endfunction

  // Memory models: address sampled on the edge where mem_en is seen, data appears RD_LAT edges later.
  always @(posedge clk) begin
    if (mem_en1) mem_rdata1 <= mem_val(mem_addr1);
    p3a        <= mem_en3 ? mem_val(mem_addr3) : 32'h0;
    p3b        <= p3a;
    mem_rdata3 <= p3b;
    p4a        <= mem_en4 ? mem_val(mem_addr4) : 32'h0;
    p4b        <= p4a;
    p4c        <= p4b;
    mem_rdata4 <= p4c;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    if_req   = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    if_addr  = 16'h0;
    dm_addr  = 16'h0;
    dm_wdata = 32'h0;
    rst      = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    int k;
    int bad;
    logic any_out;
    do_reset();
    any_out = |{if_done1, dm_done1, mem_en1, mem_we1, busy1, if_rdata1, dm_rdata1, mem_wdata1, mem_addr1,
                if_done3, dm_done3, mem_en3, mem_we3, busy3, if_rdata3, dm_rdata3, mem_wdata3, mem_addr3,
                if_done4, dm_done4, mem_en4, mem_we4, busy4, if_rdata4, dm_rdata4, mem_wdata4, mem_addr4};
    n_checks++;
    if (any_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_zero: got %b expected 0", any_out);
    end
    // Complete one fetch on the latency-3 instance so if_rdata is non-zero.
    if_req  = 1'b1;
    if_addr = 16'h0010;
    for (k = 0; k < 20; k++) begin
      tick();
      if (if_done3) break;
    end
    n_checks++;
    if (if_rdata3 !== 32'h11223344) begin
      n_fail++;
      $display("FAIL reset_prefetch_rdata: got %h expected 11223344", if_rdata3);
    end
    if_req = 1'b0;
    tick();
    tick();
    if_req = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({busy3, mem_en3} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_in_wait: busy/mem_en got %b expected 10", {busy3, mem_en3});
    end
    #4;
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_en3 !== 1'b0 || busy3 !== 1'b0 || if_done3 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async_ctrl: mem_en=%b busy=%b if_done=%b expected 000", mem_en3, busy3, if_done3);
    end
    n_checks++;
    if (if_rdata3 !== 32'h0 || mem_addr3 !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_async_data: if_rdata=%h mem_addr=%h expected 0", if_rdata3, mem_addr3);
    end
    if_req = 1'b0;
    bad = 0;
    for (k = 0; k < 8; k++) begin
      tick();
      if (k == 1) rst = 1'b0;
      if (if_done3 || mem_en3) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done_after_abort: got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_lone_fetch;
    do_reset();
    if_req  = 1'b1;
    if_addr = 16'h0010;
    tick();
    n_checks++;
    if ({mem_en1, mem_we1, busy1, if_done1} !== 4'b1010 || mem_addr1 !== 16'h0010) begin
      n_fail++;
      $display("FAIL fetch_issue: en/we/busy/done got %b addr %h expected 1010 addr 0010",
               {mem_en1, mem_we1, busy1, if_done1}, mem_addr1);
    end
    tick();
    n_checks++;
    if ({mem_en1, if_done1} !== 2'b00) begin
      n_fail++;
      $display("FAIL fetch_wait: en/done got %b expected 00", {mem_en1, if_done1});
    end
    tick();
    n_checks++;
    if (if_done1 !== 1'b1 || if_rdata1 !== 32'h11223344) begin
      n_fail++;
      $display("FAIL fetch_done: done=%b rdata=%h expected 1 11223344", if_done1, if_rdata1);
    end
    if_req = 1'b0;
    tick();
    n_checks++;
    if (if_done1 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_done_width: done=%b busy=%b expected 0 0", if_done1, busy1);
    end
    tick();
    tick();
    n_checks++;
    if (if_rdata1 !== 32'h11223344 || mem_en1 !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_rdata_hold: rdata=%h en=%b expected 11223344 0", if_rdata1, mem_en1);
    end
  endtask

  task automatic test_lone_store;
    do_reset();
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 16'h0020;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (dm_done1) break;
    end
    n_checks++;
    if (dm_rdata1 !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL store_preload: dm_rdata got %h expected cafef00d", dm_rdata1);
    end
    dm_req = 1'b0;
    tick();
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 16'h0080;
    dm_wdata = 32'hDEADBEEF;
    tick();
    n_checks++;
    if ({mem_en1, mem_we1, dm_done1} !== 3'b110 || mem_addr1 !== 16'h0080 || mem_wdata1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL store_issue: en/we/done %b addr %h wdata %h expected 110 0080 deadbeef",
               {mem_en1, mem_we1, dm_done1}, mem_addr1, mem_wdata1);
    end
    tick();
    n_checks++;
    if ({mem_en1, mem_we1, dm_done1} !== 3'b001) begin
      n_fail++;
      $display("FAIL store_done: en/we/done got %b expected 001", {mem_en1, mem_we1, dm_done1});
    end
    dm_req = 1'b0;
    dm_we  = 1'b0;
    tick();
    n_checks++;
    if (dm_done1 !== 1'b0 || busy1 !== 1'b0 || dm_rdata1 !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL store_after: done=%b busy=%b dm_rdata=%h expected 0 0 cafef00d", dm_done1, busy1, dm_rdata1);
    end
  endtask

  task automatic test_contention;
    int grants[4];
    int ngr;
    int overlap;
    logic prev_en;
    do_reset();
    if_addr = 16'h0010;
    dm_addr = 16'h0020;
    dm_we   = 1'b0;
    if_req  = 1'b1;
    dm_req  = 1'b1;
    ngr     = 0;
    overlap = 0;
    prev_en = 1'b0;
    for (int k = 0; k < 40 && ngr < 4; k++) begin
      tick();
      if (mem_en1) begin
        grants[ngr] = (mem_addr1 == 16'h0010) ? 0 : 1;
        ngr++;
      end
      if (mem_en1 && prev_en) overlap++;
      prev_en = mem_en1;
      if (if_done1) if_req = 1'b0;
      else if (!if_req) if_req = 1'b1;
      if (dm_done1) dm_req = 1'b0;
      else if (!dm_req) dm_req = 1'b1;
    end
    n_checks++;
    if (ngr !== 4) begin
      n_fail++;
      $display("FAIL contention_grant_count: got %0d expected 4", ngr);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (grants[i] !== (i % 2)) begin
          n_fail++;
          $display("FAIL contention_order[%0d]: got port %0d expected %0d", i, grants[i], i % 2);
        end
      end
    end
    n_checks++;
    if (overlap !== 0) begin
      n_fail++;
      $display("FAIL contention_en_overlap: got %0d expected 0", overlap);
    end
    n_checks++;
    if (if_rdata1 !== 32'h11223344 || dm_rdata1 !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL contention_rdata: if=%h dm=%h expected 11223344 cafef00d", if_rdata1, dm_rdata1);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    int pos[3];
    int np;
    do_reset();
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 16'h0040;
    dm_wdata = 32'h12345678;
    np = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (mem_en1 && np < 3) begin
        pos[np] = k;
        np++;
      end
    end
    n_checks++;
    if (np !== 3 || pos[0] !== 0 || pos[1] !== 3 || pos[2] !== 6) begin
      n_fail++;
      $display("FAIL back_to_back_writes: count %0d positions %0d %0d %0d expected 3 at 0 3 6",
               np, pos[0], pos[1], pos[2]);
    end
    dm_req = 1'b0;
    dm_we  = 1'b0;
    tick();
  endtask

  task automatic test_lat4_load;
    int done_k;
    int busy_cnt;
    do_reset();
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 16'h0003;
    tick();
    n_checks++;
    if (mem_en4 !== 1'b1 || mem_addr4 !== 16'h0003) begin
      n_fail++;
      $display("FAIL lat4_issue: en=%b addr=%h expected 1 0003", mem_en4, mem_addr4);
    end
    done_k   = -1;
    busy_cnt = busy4 ? 1 : 0;
    for (int k = 1; k < 12; k++) begin
      tick();
      if (dm_done4) begin
        done_k = k;
        break;
      end
      if (busy4) busy_cnt++;
    end
    n_checks++;
    if (done_k !== 5) begin
      n_fail++;
      $display("FAIL lat4_done_latency: got %0d expected 5", done_k);
    end
    n_checks++;
    if (dm_rdata4 !== 32'h0BADC0DE) begin
      n_fail++;
      $display("FAIL lat4_rdata: got %h expected 0badc0de", dm_rdata4);
    end
    n_checks++;
    if (busy_cnt !== 5) begin
      n_fail++;
      $display("FAIL lat4_busy_cycles: got %0d expected 5", busy_cnt);
    end
    dm_req = 1'b0;
    tick();
    n_checks++;
    if (busy4 !== 1'b0 || dm_done4 !== 1'b0 || dm_rdata4 !== 32'h0BADC0DE) begin
      n_fail++;
      $display("FAIL lat4_after: busy=%b done=%b rdata=%h expected 0 0 0badc0de", busy4, dm_done4, dm_rdata4);
    end
  endtask

  task automatic test_protocol_edges;
    int done_k;
    int bad;
    do_reset();
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 16'h0004;
    tick();
    dm_req = 1'b0;
    tick();
    dm_addr = 16'h0005;
    done_k  = (dm_done4) ? 1 : -1;
    bad     = (mem_addr4 !== 16'h0004) ? 1 : 0;
    for (int k = 2; k < 12 && done_k < 0; k++) begin
      tick();
      if (mem_addr4 !== 16'h0004) bad++;
      if (dm_done4) done_k = k;
    end
    n_checks++;
    if (done_k !== 5) begin
      n_fail++;
      $display("FAIL drop_req_done: latency got %0d expected 5", done_k);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL addr_latched: %0d cycles with changed mem_addr, expected 0", bad);
    end
    n_checks++;
    if (dm_rdata4 !== 32'h0004FFFB) begin
      n_fail++;
      $display("FAIL drop_req_rdata: got %h expected 0004fffb", dm_rdata4);
    end
    tick();
    tick();
    n_checks++;
    if (busy4 !== 1'b0 || mem_en4 !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_req_no_regrant: busy=%b en=%b expected 0 0", busy4, mem_en4);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_lone_fetch();
    test_lone_store();
    test_contention();
    test_back_to_back();
    test_lat4_load();
    test_protocol_edges();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
